// File: rtl/ibex_pkg.sv
// Shared ibex types used by the writeback queue.
package ibex_pkg;

  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'b00,
    WB_INSTR_STORE = 2'b01,
    WB_INSTR_OTHER = 2'b10
  } wb_instr_type_e;

endpackage

// File: rtl/ibex_wb_fwd_lookup.sv
// One RF read-address lookup against the stored writeback entries.
// Entries arrive in age order: index 0 is the oldest, Depth-1 the youngest.
module ibex_wb_fwd_lookup
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic [4:0]             raddr_i,
  input  logic [Depth-1:0]       vld_i,
  input  logic [Depth-1:0][4:0]  waddr_i,
  input  logic [Depth-1:0][31:0] wdata_i,
  input  logic [Depth-1:0]       we_i,
  input  logic [Depth-1:0]       load_i,
  output logic                   hit_o,
  output logic                   stall_o,
  output logic [31:0]            wdata_o
);

  logic        found;
  logic        sel_load;
  logic [31:0] sel_data;

  // Scan oldest to youngest so the youngest match wins; x0 never forwards.
  always_comb begin
    found    = 1'b0;
    sel_load = 1'b0;
    sel_data = '0;
    for (int k = 0; k < int'(Depth); k++) begin
      if (vld_i[k] && (raddr_i != 5'd0) && (waddr_i[k] == raddr_i) &&
          (we_i[k] || load_i[k])) begin
        found    = 1'b1;
        sel_load = load_i[k];
        sel_data = wdata_i[k];
      end
    end
  end

  assign hit_o   = found & ~sel_load;
  assign stall_o = found & sel_load;
  assign wdata_o = hit_o ? sel_data : 32'd0;

endmodule

// File: rtl/ibex_wb_queue.sv
// In-order writeback queue: circular FIFO of retiring instructions with
// RF write arbitration against LSU load data and per-port forwarding.
module ibex_wb_queue
  import ibex_pkg::*;
#(
  parameter int unsigned Depth       = 2,
  parameter int unsigned NumFwdPorts = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_wb_i,
  input  wb_instr_type_e               instr_type_wb_i,
  input  logic [31:0]                  pc_id_i,
  input  logic [4:0]                   rf_waddr_id_i,
  input  logic [31:0]                  rf_wdata_id_i,
  input  logic                         rf_we_id_i,
  output logic                         ready_wb_o,
  input  logic                         lsu_resp_valid_i,
  input  logic [31:0]                  rf_wdata_lsu_i,
  input  logic                         rf_we_lsu_i,
  output logic [4:0]                   rf_waddr_wb_o,
  output logic [31:0]                  rf_wdata_wb_o,
  output logic                         rf_we_wb_o,
  output logic [31:0]                  pc_wb_o,
  output logic                         instr_done_wb_o,
  output logic                         outstanding_load_wb_o,
  output logic                         outstanding_store_wb_o,
  input  logic [NumFwdPorts-1:0][4:0]  fwd_raddr_i,
  output logic [NumFwdPorts-1:0]       fwd_hit_o,
  output logic [NumFwdPorts-1:0]       fwd_stall_o,
  output logic [NumFwdPorts-1:0][31:0] fwd_wdata_o,
  output logic [$clog2(Depth+1)-1:0]   occupancy_o
);

  localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned OW = $clog2(Depth+1);

  logic [Depth-1:0]                 vld;
  wb_instr_type_e [Depth-1:0]       typ_q;
  logic [Depth-1:0][31:0]           pc_q, wdata_q;
  logic [Depth-1:0][4:0]            waddr_q;
  logic [Depth-1:0]                 we_q;
  logic [PW-1:0]                    rd_ptr, wr_ptr;
  logic [OW-1:0]                    cnt;

  logic h_vld, head_done, enq, q_we;
  wb_instr_type_e h_typ;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(Depth-1)) ? '0 : p + 1'b1;
  endfunction

  assign h_vld     = vld[rd_ptr];
  assign h_typ     = typ_q[rd_ptr];
  assign head_done = h_vld & ((h_typ == WB_INSTR_OTHER) | lsu_resp_valid_i);
  assign ready_wb_o = (cnt != OW'(Depth)) | head_done;
  assign enq       = en_wb_i & ready_wb_o;
  assign q_we      = head_done & we_q[rd_ptr];

  assign instr_done_wb_o = head_done;
  assign rf_we_wb_o      = q_we | rf_we_lsu_i;
  assign rf_wdata_wb_o   = q_we ? wdata_q[rd_ptr] : rf_wdata_lsu_i;
  assign rf_waddr_wb_o   = waddr_q[rd_ptr];
  assign pc_wb_o         = h_vld ? pc_q[rd_ptr] : 32'd0;
  assign occupancy_o     = cnt;

  // Control state: retire clears the head first so a same-slot enqueue wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (head_done) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= nxt(rd_ptr);
      end
      if (enq) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (enq && !head_done)      cnt <= cnt + 1'b1;
      else if (!enq && head_done) cnt <= cnt - 1'b1;
    end
  end

  // Payload capture; validity is tracked separately so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      typ_q[wr_ptr]   <= instr_type_wb_i;
      pc_q[wr_ptr]    <= pc_id_i;
      waddr_q[wr_ptr] <= rf_waddr_id_i;
      wdata_q[wr_ptr] <= rf_wdata_id_i;
      we_q[wr_ptr]    <= rf_we_id_i;
    end
  end

  // Outstanding memory operations anywhere in the queue.
  always_comb begin
    outstanding_load_wb_o  = 1'b0;
    outstanding_store_wb_o = 1'b0;
    for (int k = 0; k < int'(Depth); k++) begin
      if (vld[k] && typ_q[k] == WB_INSTR_LOAD)  outstanding_load_wb_o  = 1'b1;
      if (vld[k] && typ_q[k] == WB_INSTR_STORE) outstanding_store_wb_o = 1'b1;
    end
  end

  logic [Depth-1:0]       a_vld, a_we, a_load;
  logic [Depth-1:0][4:0]  a_waddr;
  logic [Depth-1:0][31:0] a_wdata;

  // Rotate stored entries into age order starting from the head.
  always_comb begin
    a_vld   = '0;
    a_we    = '0;
    a_load  = '0;
    a_waddr = '0;
    a_wdata = '0;
    for (int k = 0; k < int'(Depth); k++) begin
      int s;
      logic [PW-1:0] idx;
      s = int'(rd_ptr) + k;
      if (s >= int'(Depth)) s = s - int'(Depth);
      idx        = PW'(s);
      a_vld[k]   = vld[idx];
      a_we[k]    = we_q[idx];
      a_load[k]  = (typ_q[idx] == WB_INSTR_LOAD);
      a_waddr[k] = waddr_q[idx];
      a_wdata[k] = wdata_q[idx];
    end
  end

  for (genvar p = 0; p < int'(NumFwdPorts); p++) begin : g_fwd
    ibex_wb_fwd_lookup #(.Depth(Depth)) u_lkp (
      .raddr_i (fwd_raddr_i[p]),
      .vld_i   (a_vld),
      .waddr_i (a_waddr),
      .wdata_i (a_wdata),
      .we_i    (a_we),
      .load_i  (a_load),
      .hit_o   (fwd_hit_o[p]),
      .stall_o (fwd_stall_o[p]),
      .wdata_o (fwd_wdata_o[p])
    );
  end

  a_wr_excl: assert property (@(posedge clk_i) disable iff (rst_i)
    !(q_we && rf_we_lsu_i));
  a_stray_resp: assert property (@(posedge clk_i) disable iff (rst_i)
    lsu_resp_valid_i |-> (h_vld && h_typ != WB_INSTR_OTHER));

endmodule

// File: doc/ibex_wb_queue.md
IBEX_WB_QUEUE -- requirements
Module: ibex_wb_queue

Interface
REQ-001 SHALL have parameter Depth, default 2, number of writeback entries (legal 1..8, power of two not required).
REQ-002 SHALL have parameter NumFwdPorts, default 2, number of RF read-address forwarding lookups.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous assert, active-high.
REQ-005 SHALL have port en_wb_i  input  1  ID/EX offers an instruction.
REQ-006 SHALL have port instr_type_wb_i  input  wb_instr_type_e  LOAD/STORE/OTHER.
REQ-007 SHALL have ports pc_id_i  input  32; rf_waddr_id_i  input  5; rf_wdata_id_i  input  32; rf_we_id_i  input  1  offered entry payload.
REQ-008 SHALL have port ready_wb_o  output  1  queue accepts offer this cycle.
REQ-009 SHALL have port lsu_resp_valid_i  input  1  LSU response for oldest outstanding load/store.
REQ-010 SHALL have ports rf_wdata_lsu_i  input  32; rf_we_lsu_i  input  1  load data write request.
REQ-011 SHALL have ports rf_waddr_wb_o  output  5; rf_wdata_wb_o  output  32; rf_we_wb_o  output  1  RF write port.
REQ-012 SHALL have ports pc_wb_o  output  32; instr_done_wb_o  output  1  head PC and head retire strobe.
REQ-013 SHALL have ports outstanding_load_wb_o, outstanding_store_wb_o  output  1  any valid LOAD/STORE entry.
REQ-014 SHALL have ports fwd_raddr_i  input  NumFwdPorts x 5; fwd_hit_o, fwd_stall_o  output  NumFwdPorts x 1; fwd_wdata_o  output  NumFwdPorts x 32.
REQ-015 SHALL have port occupancy_o  output  $clog2(Depth+1)  valid entry count.

Function
REQ-016 Entries SHALL form in-order circular FIFO; rd/wr pointers wrap from Depth-1 to 0.
REQ-017 Enqueue SHALL occur when en_wb_i & ready_wb_o; entry valid from next cycle (1-cycle latency minimum).
REQ-018 head_done SHALL be head valid & (type OTHER | lsu_resp_valid_i).
REQ-019 ready_wb_o SHALL be ~full | head_done (enqueue and retire when full allowed same cycle).
REQ-020 At most one entry SHALL retire per cycle, always the head; instr_done_wb_o = head valid & head_done.
REQ-021 Simultaneous enqueue and retire SHALL leave occupancy unchanged; empty queue SHALL never retire the entry enqueued that cycle.
REQ-022 Queue-side RF write SHALL be head valid & head rf_we & head_done, address head waddr, data head wdata.
REQ-023 rf_we_wb_o SHALL be OR of queue-side and rf_we_lsu_i; rf_wdata_wb_o SHALL select queue data when queue-side write active, else rf_wdata_lsu_i; rf_waddr_wb_o SHALL be head waddr.
REQ-024 Queue-side and LSU writes SHALL be mutually exclusive (assertion).
REQ-025 lsu_resp_valid_i with queue empty or head OTHER SHALL be ignored and flagged by assertion.
REQ-026 Forwarding per port: youngest valid entry with matching waddr and (rf_we or type LOAD) selected; waddr 0 never matches.
REQ-027 Selected non-LOAD entry with rf_we: fwd_hit_o=1, fwd_wdata_o=entry wdata, fwd_stall_o=0.
REQ-028 Selected LOAD entry: fwd_stall_o=1, fwd_hit_o=0; no match: both 0, fwd_wdata_o=0.
REQ-029 Forwarding SHALL use stored entries only (no combinational path from rf_wdata_lsu_i or ID inputs).
REQ-030 pc_wb_o SHALL be head PC when head valid, else 0.

Reset
REQ-031 rst_i SHALL clear all valid bits, pointers and occupancy immediately, including mid-operation with outstanding loads.
REQ-032 In reset: ready_wb_o=1, rf_we_wb_o=0 unless rf_we_lsu_i, instr_done_wb_o=0, outstanding_*=0, fwd_*=0, occupancy_o=0, pc_wb_o=0.
REQ-033 Payload storage SHALL need no reset.

Structure
REQ-034 wb_instr_type_e SHALL come from ibex_pkg; no new package types needed.
REQ-035 Per-port lookup SHALL be sub-module ibex_wb_fwd_lookup, instantiated NumFwdPorts times.
REQ-036 Depth=1 SHALL behave as the single-entry writeback stage.

Verification
REQ-037 Depth=2: enqueue OTHER x5 rd=x3 wdata=0x11.. back-to-back -> ready stays 1, one RF write per cycle, occupancy <=1.
REQ-038 Depth=2: LOAD rd=x5 then OTHER rd=x6, no response -> occupancy 2, ready 0, fwd x5 stall=1, fwd x6 hit data; response -> LOAD retires, OTHER retires next cycle.
REQ-039 Full queue + lsu_resp_valid_i + en_wb_i same cycle -> enqueue accepted, occupancy stays 2.
REQ-040 Two entries rd=x7 wdata 0xA then 0xB -> fwd_wdata_o=0xB; rd=x0 -> no hit.
REQ-041 rst_i pulse with 2 outstanding loads -> occupancy 0, outstanding_load_wb_o=0 same cycle; later stray lsu_resp_valid_i ignored.
REQ-042 Depth=3 wrap test: 10 mixed entries -> retire order and PCs match enqueue order.
